// File: rtl/timer_dp.sv
// -----------------------------------------------------------------------------
// timer_dp
//
// Stopwatch / countdown timer datapath. It keeps hours, minutes, seconds and
// hundredths, counting up (stopwatch) or down (countdown) once per 10 ms tick.
// A clock-enabled prescaler produces the ticks. The block also supports a
// preset load, lap capture and a sticky expiry flag. All time fields are
// updated together on the edge where the prescaler wraps, so no field ever
// shows an intermediate carry/borrow value.
//
// Parameters
//   TICK_DIV  clk cycles per 10 ms tick (>= 2)
//   HOUR_MOD  hour modulus (2..32)
//
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   run_stop      in   level: 1 = counting, 0 = paused
//   clear         in   sync pulse: zero time, prescaler, done and lap_time
//   mode          in   0 = count up, 1 = count down
//   load          in   sync pulse: load saturated preset fields
//   preset_msec   in   7-bit hundredths preset
//   preset_sec    in   6-bit seconds preset
//   preset_min    in   6-bit minutes preset
//   preset_hour   in   5-bit hours preset
//   lap           in   sync pulse: capture the current time
//   msec          out  7-bit hundredths (0..99)
//   sec           out  6-bit seconds (0..59)
//   min           out  6-bit minutes (0..59)
//   hour          out  5-bit hours (0..HOUR_MOD-1)
//   lap_time      out  {hour, min, sec, msec} captured by lap
//   lap_valid     out  one-cycle pulse after a capture
//   tick_10ms     out  one-cycle pulse while a freshly advanced time is shown
//   done          out  sticky: countdown reached zero
//
// Edge priority: clear > load > advance. Lap capture runs in parallel with
// that chain, but a clear on the same edge discards it.
// -----------------------------------------------------------------------------
module timer_dp #(
    parameter int TICK_DIV = 1_000_000,
    parameter int HOUR_MOD = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run_stop,
    input  logic        clear,
    input  logic        mode,
    input  logic        load,
    input  logic [6:0]  preset_msec,
    input  logic [5:0]  preset_sec,
    input  logic [5:0]  preset_min,
    input  logic [4:0]  preset_hour,
    input  logic        lap,
    output logic [6:0]  msec,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic [23:0] lap_time,
    output logic        lap_valid,
    output logic        tick_10ms,
    output logic        done
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [6:0]      MSEC_MAX  = 7'd99;
    localparam logic [5:0]      SEC_MAX   = 6'd59;
    localparam logic [5:0]      MIN_MAX   = 6'd59;
    localparam logic [4:0]      HOUR_MAX  = 5'(HOUR_MOD - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q,     presc_d;
    logic [6:0]    msec_q,      msec_d;
    logic [5:0]    sec_q,       sec_d;
    logic [5:0]    min_q,       min_d;
    logic [4:0]    hour_q,      hour_d;
    logic          done_q,      done_d;
    logic          tick_q,      tick_d;
    logic [23:0]   lap_time_q,  lap_time_d;
    logic          lap_valid_q, lap_valid_d;

    // ------------------------------------------------------------------
    // Enable and prescaler wrap
    // ------------------------------------------------------------------
    // An expired countdown freezes the prescaler and the time fields.
    // In up mode a set done flag has no effect on counting.
    logic en;
    logic wrap;

    assign en   = run_stop & ~(mode & done_q);
    assign wrap = en & (presc_q == PRESC_MAX);

    // ------------------------------------------------------------------
    // Up-count candidate: full carry chain evaluated in one cycle
    // ------------------------------------------------------------------
    logic [6:0] up_msec;
    logic [5:0] up_sec;
    logic [5:0] up_min;
    logic [4:0] up_hour;

    always_comb begin
        up_msec = msec_q;
        up_sec  = sec_q;
        up_min  = min_q;
        up_hour = hour_q;
        if (msec_q != MSEC_MAX) begin
            up_msec = msec_q + 7'd1;
        end else begin
            up_msec = 7'd0;
            if (sec_q != SEC_MAX) begin
                up_sec = sec_q + 6'd1;
            end else begin
                up_sec = 6'd0;
                if (min_q != MIN_MAX) begin
                    up_min = min_q + 6'd1;
                end else begin
                    up_min  = 6'd0;
                    up_hour = (hour_q >= HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Down-count candidate: full borrow chain evaluated in one cycle
    // ------------------------------------------------------------------
    logic [6:0] dn_msec;
    logic [5:0] dn_sec;
    logic [5:0] dn_min;
    logic [4:0] dn_hour;
    logic       time_zero;
    logic       dn_zero;

    assign time_zero = (msec_q == 7'd0) && (sec_q == 6'd0) &&
                       (min_q == 6'd0)  && (hour_q == 5'd0);

    always_comb begin
        dn_msec = msec_q;
        dn_sec  = sec_q;
        dn_min  = min_q;
        dn_hour = hour_q;
        // Already at zero: the time holds and expiry is still flagged below.
        if (!time_zero) begin
            if (msec_q != 7'd0) begin
                dn_msec = msec_q - 7'd1;
            end else begin
                dn_msec = MSEC_MAX;
                if (sec_q != 6'd0) begin
                    dn_sec = sec_q - 6'd1;
                end else begin
                    dn_sec = SEC_MAX;
                    if (min_q != 6'd0) begin
                        dn_min = min_q - 6'd1;
                    end else begin
                        dn_min = MIN_MAX;
                        // hour is non-zero here, otherwise time_zero would be set.
                        dn_hour = (hour_q != 5'd0) ? hour_q - 5'd1 : HOUR_MAX;
                    end
                end
            end
        end
    end

    // Expiry occurs when the decremented value is zero. The case where the
    // time was already zero is included.
    assign dn_zero = (dn_msec == 7'd0) && (dn_sec == 6'd0) &&
                     (dn_min == 6'd0)  && (dn_hour == 5'd0);

    // ------------------------------------------------------------------
    // Preset saturation
    // ------------------------------------------------------------------
    logic [6:0] sat_msec;
    logic [5:0] sat_sec;
    logic [5:0] sat_min;
    logic [4:0] sat_hour;

    always_comb begin
        sat_msec = (preset_msec > MSEC_MAX) ? MSEC_MAX : preset_msec;
        sat_sec  = (preset_sec  > SEC_MAX)  ? SEC_MAX  : preset_sec;
        sat_min  = (preset_min  > MIN_MAX)  ? MIN_MAX  : preset_min;
        sat_hour = (preset_hour > HOUR_MAX) ? HOUR_MAX : preset_hour;
    end

    // ------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------
    always_comb begin
        presc_d     = presc_q;
        msec_d      = msec_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        done_d      = done_q;
        tick_d      = 1'b0;
        lap_time_d  = lap_time_q;
        lap_valid_d = 1'b0;

        // Lap captures the time value from before this edge.
        if (lap) begin
            lap_time_d  = {hour_q, min_q, sec_q, msec_q};
            lap_valid_d = 1'b1;
        end

        if (clear) begin
            presc_d     = '0;
            msec_d      = 7'd0;
            sec_d       = 6'd0;
            min_d       = 6'd0;
            hour_d      = 5'd0;
            done_d      = 1'b0;
            lap_time_d  = 24'd0;
            lap_valid_d = 1'b0;
        end else if (load) begin
            presc_d = '0;
            msec_d  = sat_msec;
            sec_d   = sat_sec;
            min_d   = sat_min;
            hour_d  = sat_hour;
            done_d  = 1'b0;
        end else if (en) begin
            if (wrap) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (mode) begin
                    msec_d = dn_msec;
                    sec_d  = dn_sec;
                    min_d  = dn_min;
                    hour_d = dn_hour;
                    if (dn_zero) begin
                        done_d = 1'b1;
                    end
                end else begin
                    msec_d = up_msec;
                    sec_d  = up_sec;
                    min_d  = up_min;
                    hour_d = up_hour;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            msec_q      <= 7'd0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 5'd0;
            done_q      <= 1'b0;
            tick_q      <= 1'b0;
            lap_time_q  <= 24'd0;
            lap_valid_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            msec_q      <= msec_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            done_q      <= done_d;
            tick_q      <= tick_d;
            lap_time_q  <= lap_time_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign msec      = msec_q;
    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign lap_time  = lap_time_q;
    assign lap_valid = lap_valid_q;
    assign tick_10ms = tick_q;
    assign done      = done_q;

endmodule

// File: tb/tb_timer_dp.sv
// -----------------------------------------------------------------------------
// tb_timer_dp
//
// Directed scenarios followed by a randomized run for timer_dp
// (TICK_DIV=4, HOUR_MOD=24). The reference model holds the time as one
// integer count of hundredths of a second. It advances that integer with
// plain modular arithmetic and unpacks it into fields only to compare.
// -----------------------------------------------------------------------------
module tb_timer_dp;

    localparam int TICK_DIV = 4;
    localparam int HOUR_MOD = 24;
    localparam int FULL     = HOUR_MOD * 360000;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        run_stop, clear, mode, load, lap;
    logic [6:0]  preset_msec;
    logic [5:0]  preset_sec, preset_min;
    logic [4:0]  preset_hour;
    logic [6:0]  msec;
    logic [5:0]  sec, min;
    logic [4:0]  hour;
    logic [23:0] lap_time;
    logic        lap_valid, tick_10ms, done;

    always #5 clk = ~clk;

    timer_dp #(.TICK_DIV(TICK_DIV), .HOUR_MOD(HOUR_MOD)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run_stop    (run_stop),
        .clear       (clear),
        .mode        (mode),
        .load        (load),
        .preset_msec (preset_msec),
        .preset_sec  (preset_sec),
        .preset_min  (preset_min),
        .preset_hour (preset_hour),
        .lap         (lap),
        .msec        (msec),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .lap_time    (lap_time),
        .lap_valid   (lap_valid),
        .tick_10ms   (tick_10ms),
        .done        (done)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int          m_t;       // current time in hundredths
    int          m_presc;   // enabled cycles since the last tick
    bit          m_done;
    logic [23:0] m_lap;
    bit          m_lapv;
    bit          m_tick;

    int tests_run = 0;
    int tests_failed = 0;

    function automatic logic [23:0] pack(input int t);
        int h, m, s, c;
        h = t / 360000;
        m = (t / 6000) % 60;
        s = (t / 100) % 60;
        c = t % 100;
        return {5'(h), 6'(m), 6'(s), 7'(c)};
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        m_t = 0; m_presc = 0; m_done = 0; m_lap = '0; m_lapv = 0; m_tick = 0;
    endtask

    // Applies one clock edge using the input values present before it.
    task automatic model_edge();
        bit en;
        int prev_t;
        en     = run_stop && !(mode && m_done);
        prev_t = m_t;
        m_tick = 0;
        if (clear) begin
            m_t = 0; m_presc = 0; m_done = 0; m_lap = '0; m_lapv = 0;
        end else begin
            m_lapv = lap;
            if (lap) m_lap = pack(prev_t);
            if (load) begin
                m_t = clampi(int'(preset_hour), HOUR_MOD - 1) * 360000 +
                      clampi(int'(preset_min), 59) * 6000 +
                      clampi(int'(preset_sec), 59) * 100 +
                      clampi(int'(preset_msec), 99);
                m_presc = 0;
                m_done  = 0;
            end else if (en) begin
                if (m_presc == TICK_DIV - 1) begin
                    m_presc = 0;
                    m_tick  = 1;
                    if (!mode) begin
                        m_t = (m_t + 1) % FULL;
                    end else begin
                        m_t    = (m_t > 0) ? m_t - 1 : 0;
                        if (m_t == 0) m_done = 1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [23:0] now;
        now = pack(m_t);
        check({where, ".msec"},      32'(msec),      32'(now[6:0]));
        check({where, ".sec"},       32'(sec),       32'(now[12:7]));
        check({where, ".min"},       32'(min),       32'(now[18:13]));
        check({where, ".hour"},      32'(hour),      32'(now[23:19]));
        check({where, ".lap_time"},  32'(lap_time),  32'(m_lap));
        check({where, ".lap_valid"}, 32'(lap_valid), 32'(m_lapv));
        check({where, ".tick"},      32'(tick_10ms), 32'(m_tick));
        check({where, ".done"},      32'(done),      32'(m_done));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        #1;
        check_all(where);
    endtask

    task automatic steps(input int n, input string where);
        for (int i = 0; i < n; i++) step(where);
    endtask

    task automatic do_load(input int h, input int m, input int s, input int c, input string where);
        preset_hour = 5'(h); preset_min = 6'(m); preset_sec = 6'(s); preset_msec = 7'(c);
        load = 1'b1;
        step(where);
        load = 1'b0;
    endtask

    task automatic do_clear(input string where);
        clear = 1'b1;
        step(where);
        clear = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset_n = 1'b0;
        run_stop = 0; clear = 0; mode = 0; load = 0; lap = 0;
        preset_msec = '0; preset_sec = '0; preset_min = '0; preset_hour = '0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Up count from reset
        run_stop = 1'b1;
        steps(3, "up_pre");
        step("up_tick1");
        check("up_msec1", 32'(msec), 32'd1);
        check("up_tick_hi", 32'(tick_10ms), 32'd1);
        step("up_after");
        check("up_tick_lo", 32'(tick_10ms), 32'd0);
        steps(3, "up_tick2");
        check("up_msec2", 32'(msec), 32'd2);

        // Carry across every field on one edge
        do_load(0, 59, 59, 99, "ld_carry");
        steps(4, "carry");
        check("carry_hour", 32'(hour), 32'd1);
        check("carry_rest", 32'({min, sec, msec}), 32'd0);

        // Full-scale wrap
        do_load(23, 59, 59, 99, "ld_wrap");
        steps(4, "wrap");
        check("wrap_time", 32'({hour, min, sec, msec}), 32'd0);
        check("wrap_done", 32'(done), 32'd0);

        // Countdown with borrow
        mode = 1'b1;
        do_load(0, 0, 1, 0, "ld_down");
        steps(4, "down");
        check("down_msec", 32'(msec), 32'd99);
        check("down_sec", 32'(sec), 32'd0);

        // Countdown to zero, then frozen
        do_load(0, 0, 0, 2, "ld_zero");
        steps(8, "to_zero");
        check("zero_done", 32'(done), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step("frozen");
            check("frozen_tick", 32'(tick_10ms), 32'd0);
        end
        check("frozen_time", 32'({hour, min, sec, msec}), 32'd0);

        // Pause keeps the prescaler phase
        mode = 1'b0;
        do_clear("clr_pause");
        steps(2, "pause_run");
        run_stop = 1'b0;
        steps(10, "paused");
        run_stop = 1'b1;
        step("resume1");
        check("resume_notick", 32'(tick_10ms), 32'd0);
        step("resume2");
        check("resume_tick", 32'(tick_10ms), 32'd1);
        check("resume_msec", 32'(msec), 32'd1);

        // Lap on an advance edge
        do_clear("clr_lap");
        steps(23, "lap_run");
        lap = 1'b1;
        step("lap_edge");
        lap = 1'b0;
        check("lap_msec_field", 32'(lap_time[6:0]), 32'd5);
        check("lap_msec_now", 32'(msec), 32'd6);
        check("lap_valid_hi", 32'(lap_valid), 32'd1);
        step("lap_next");
        check("lap_valid_lo", 32'(lap_valid), 32'd0);

        // Lap together with clear is discarded
        lap = 1'b1; clear = 1'b1;
        step("lap_clear");
        lap = 1'b0; clear = 1'b0;
        check("lapclr_time", 32'(lap_time), 32'd0);
        check("lapclr_valid", 32'(lap_valid), 32'd0);

        // Clear beats load
        steps(9, "pre_clrld");
        preset_msec = 7'd50; preset_sec = 6'd10;
        clear = 1'b1; load = 1'b1;
        step("clr_ld");
        clear = 1'b0; load = 1'b0;
        check("clrld_time", 32'({hour, min, sec, msec}), 32'd0);

        // Saturation
        do_load(30, 63, 63, 120, "sat");
        check("sat_msec", 32'(msec), 32'd99);
        check("sat_sec", 32'(sec), 32'd59);
        check("sat_min", 32'(min), 32'd59);
        check("sat_hour", 32'(hour), 32'd23);

        // Asynchronous reset mid-count
        steps(6, "pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        reset_n = 1'b1;
        steps(3, "post_rst");
        step("post_rst_tick");
        check("post_rst_msec", 32'(msec), 32'd1);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            clear    = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 39) == 0);
            lap      = ($urandom_range(0, 7) == 0);
            run_stop = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if ($urandom_range(0, 1) == 0) begin
                preset_hour = 5'($urandom_range(0, 31));
                preset_min  = 6'($urandom_range(0, 63));
                preset_sec  = 6'($urandom_range(0, 63));
                preset_msec = 7'($urandom_range(0, 127));
            end else begin
                preset_hour = 5'd0;
                preset_min  = 6'd0;
                preset_sec  = 6'($urandom_range(0, 1));
                preset_msec = 7'($urandom_range(0, 5));
            end
            step("rand");
        end
        clear = 0; load = 0; lap = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
